// File: rtl/x_operand_select_if.sv
// x_operand_select_if: bundles the register file, result bus, prefix decode
// inputs and X-operand/index outputs of x_operand_select_ctrl.
// The master side drives the decode and data inputs; the slave side is the controller.
interface x_operand_select_if #(
    parameter int WIDTH  = 16,
    parameter int RSEL_W = 4
);
    localparam int NREGS = 2 ** RSEL_W;

    logic [NREGS*WIDTH-1:0] regs;
    logic [WIDTH-1:0]       y;
    logic                   hold_load;
    logic                   op_valid;
    logic [1:0]             op_kind;
    logic [RSEL_W-1:0]      op_reg;
    logic [1:0]             xsel;
    logic [RSEL_W-1:0]      fix_idx;
    logic [WIDTH-1:0]       xbus;
    logic [RSEL_W-1:0]      sreg_idx;
    logic [RSEL_W-1:0]      dreg_idx;
    logic                   b_flag;
    logic                   move_strobe;

    modport master (
        output regs, y, hold_load, op_valid, op_kind, op_reg, xsel, fix_idx,
        input  xbus, sreg_idx, dreg_idx, b_flag, move_strobe
    );

    modport slave (
        input  regs, y, hold_load, op_valid, op_kind, op_reg, xsel, fix_idx,
        output xbus, sreg_idx, dreg_idx, b_flag, move_strobe
    );
endinterface

// File: rtl/x_operand_select_ctrl.sv
// x_operand_select_ctrl: X-operand multiplexer with FROM/TO/WITH prefix
// tracking, a hold register for the result bus, and a MOVE/MOVES strobe.
// Optional macro XSEL_OUT_REG_EN registers xbus (one cycle latency, resets
// to 0); without it xbus is combinational from the current inputs and state.
module x_operand_select_ctrl #(
    parameter int WIDTH  = 16,
    parameter int RSEL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    x_operand_select_if.slave    bus
);
    localparam int NREGS = 2 ** RSEL_W;

    localparam logic [1:0] KIND_NORMAL = 2'b00;
    localparam logic [1:0] KIND_FROM   = 2'b01;
    localparam logic [1:0] KIND_TO     = 2'b10;
    localparam logic [1:0] KIND_WITH   = 2'b11;

    localparam logic [1:0] XSEL_SREG = 2'b00;
    localparam logic [1:0] XSEL_FIX  = 2'b01;
    localparam logic [1:0] XSEL_Y    = 2'b10;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_SRC,
        ST_DST,
        ST_BOTH,
        ST_WITH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RSEL_W-1:0] sreg;
    logic [RSEL_W-1:0] sreg_nxt;
    logic [RSEL_W-1:0] dreg;
    logic [RSEL_W-1:0] dreg_nxt;
    logic              strobe;
    logic              strobe_nxt;
    logic [WIDTH-1:0]  hold;
    logic [WIDTH-1:0]  reg_arr [NREGS];
    logic [WIDTH-1:0]  xmux;

    // Unpack the flattened register file so it can be indexed directly.
    always_comb begin
        for (int n = 0; n < NREGS; n++) begin
            reg_arr[n] = bus.regs[n*WIDTH +: WIDTH];
        end
    end

    // Prefix state, index and strobe registers; reset drops any pending prefix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_CLEAR;
            sreg   <= '0;
            dreg   <= '0;
            strobe <= 1'b0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            dreg   <= dreg_nxt;
            strobe <= strobe_nxt;
        end
    end

    // Prefix decode: FROM/TO accumulate indices, WITH arms MOVE/MOVES,
    // a FROM/TO after WITH fires the strobe, and a normal op clears everything.
    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        dreg_nxt   = dreg;
        strobe_nxt = 1'b0;
        if (bus.op_valid) begin
            case (bus.op_kind)
                KIND_WITH: begin
                    state_nxt = ST_WITH;
                    sreg_nxt  = bus.op_reg;
                    dreg_nxt  = bus.op_reg;
                end
                KIND_FROM, KIND_TO: begin
                    if (state == ST_WITH) begin
                        // MOVE/MOVES executes now; indices do not pick up op_reg.
                        strobe_nxt = 1'b1;
                        state_nxt  = ST_CLEAR;
                        sreg_nxt   = '0;
                        dreg_nxt   = '0;
                    end else if (bus.op_kind == KIND_FROM) begin
                        sreg_nxt = bus.op_reg;
                        if (state == ST_CLEAR) begin
                            state_nxt = ST_SRC;
                        end else if (state == ST_DST) begin
                            state_nxt = ST_BOTH;
                        end
                    end else begin
                        dreg_nxt = bus.op_reg;
                        if (state == ST_CLEAR) begin
                            state_nxt = ST_DST;
                        end else if (state == ST_SRC) begin
                            state_nxt = ST_BOTH;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_CLEAR;
                    sreg_nxt  = '0;
                    dreg_nxt  = '0;
                end
            endcase
        end
    end

    // Hold register captures the result bus on request, independent of decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
        end else if (bus.hold_load) begin
            hold <= bus.y;
        end
    end

    // X operand source select; uses the index in effect before this cycle's edge.
    always_comb begin
        case (bus.xsel)
            XSEL_SREG: xmux = reg_arr[sreg];
            XSEL_FIX:  xmux = reg_arr[bus.fix_idx];
            XSEL_Y:    xmux = bus.y;
            default:   xmux = hold;
        endcase
    end

`ifdef XSEL_OUT_REG_EN
    logic [WIDTH-1:0] xbus_p1;

    // Output register stage for xbus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xbus_p1 <= '0;
        end else begin
            xbus_p1 <= xmux;
        end
    end

    assign bus.xbus = xbus_p1;
`else
    assign bus.xbus = xmux;
`endif

    assign bus.sreg_idx    = sreg;
    assign bus.dreg_idx    = dreg;
    assign bus.b_flag      = (state == ST_WITH);
    assign bus.move_strobe = strobe;

endmodule

// File: tb/tb_x_operand_select_ctrl.sv
// tb_x_operand_select_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the operand selector.
module tb_x_operand_select_ctrl;
    localparam int WIDTH  = 16;
    localparam int RSEL_W = 4;
    localparam int NREGS  = 2 ** RSEL_W;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;

    x_operand_select_if #(.WIDTH(WIDTH), .RSEL_W(RSEL_W)) bus ();

    x_operand_select_ctrl #(.WIDTH(WIDTH), .RSEL_W(RSEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: only the observable quantities are tracked.
    logic [RSEL_W-1:0] m_src;
    logic [RSEL_W-1:0] m_dst;
    logic              m_with;
    logic              m_strobe;
    logic [WIDTH-1:0]  m_hold;
    logic [WIDTH-1:0]  m_xq;

    function automatic logic [WIDTH-1:0] reg_of(input logic [RSEL_W-1:0] idx);
        return bus.regs[int'(idx)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] model_x();
        case (bus.xsel)
            2'b00:   return reg_of(m_src);
            2'b01:   return reg_of(bus.fix_idx);
            2'b10:   return bus.y;
            default: return m_hold;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_src    <= '0;
            m_dst    <= '0;
            m_with   <= 1'b0;
            m_strobe <= 1'b0;
            m_hold   <= '0;
            m_xq     <= '0;
        end else begin
            m_xq     <= model_x();
            m_strobe <= 1'b0;
            if (bus.hold_load) m_hold <= bus.y;
            if (bus.op_valid) begin
                if (bus.op_kind == 2'b11) begin
                    m_with <= 1'b1;
                    m_src  <= bus.op_reg;
                    m_dst  <= bus.op_reg;
                end else if (bus.op_kind == 2'b00 || m_with) begin
                    m_with   <= 1'b0;
                    m_src    <= '0;
                    m_dst    <= '0;
                    m_strobe <= (bus.op_kind != 2'b00);
                end else if (bus.op_kind == 2'b01) begin
                    m_src <= bus.op_reg;
                end else begin
                    m_dst <= bus.op_reg;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
`ifdef XSEL_OUT_REG_EN
            chk("xbus", 32'(bus.xbus), 32'(m_xq));
`else
            chk("xbus", 32'(bus.xbus), 32'(model_x()));
`endif
            chk("sreg_idx", 32'(bus.sreg_idx), 32'(m_src));
            chk("dreg_idx", 32'(bus.dreg_idx), 32'(m_dst));
            chk("b_flag", 32'(bus.b_flag), 32'(m_with));
            chk("move_strobe", 32'(bus.move_strobe), 32'(m_strobe));
        end
    end

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic [1:0] k, input logic [RSEL_W-1:0] r);
        bus.op_valid = v;
        bus.op_kind  = k;
        bus.op_reg   = r;
    endtask

    initial begin
        reset         = 1'b1;
        bus.regs      = '0;
        bus.y         = '0;
        bus.hold_load = 1'b0;
        set_op(1'b0, 2'b00, '0);
        bus.xsel      = 2'b00;
        bus.fix_idx   = '0;
        for (int i = 0; i < NREGS; i++) bus.regs[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        bus.regs[0 +: WIDTH] = 16'h1234;
        advance();
        advance();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state and plain Sreg selection.
        settle();
        chk("rst_sreg", 32'(bus.sreg_idx), 0);
        chk("rst_dreg", 32'(bus.dreg_idx), 0);
        chk("rst_b", 32'(bus.b_flag), 0);
        chk("rst_strobe", 32'(bus.move_strobe), 0);
`ifdef XSEL_OUT_REG_EN
        chk("rst_xbus_reg", 32'(bus.xbus), 0);
        advance();
        settle();
`endif
        chk("r0_xbus", 32'(bus.xbus), 32'h1234);

        // FROM 5, TO 9, then a normal op reading R5.
        advance();
        bus.regs[5*WIDTH +: WIDTH] = 16'hA5A5;
        set_op(1'b1, 2'b01, 4'd5);
        advance();
        set_op(1'b1, 2'b10, 4'd9);
        advance();
        set_op(1'b1, 2'b00, 4'd0);
        settle();
        chk("both_sreg", 32'(bus.sreg_idx), 5);
        chk("both_dreg", 32'(bus.dreg_idx), 9);
`ifndef XSEL_OUT_REG_EN
        chk("both_xbus", 32'(bus.xbus), 32'hA5A5);
`endif
        advance();
        set_op(1'b0, 2'b00, 4'd0);
        settle();
`ifdef XSEL_OUT_REG_EN
        chk("both_xbus", 32'(bus.xbus), 32'hA5A5);
`endif
        chk("clr_sreg", 32'(bus.sreg_idx), 0);
        chk("clr_dreg", 32'(bus.dreg_idx), 0);

        // WITH 3 then TO 7 fires MOVE and clears indices.
        advance();
        set_op(1'b1, 2'b11, 4'd3);
        advance();
        set_op(1'b1, 2'b10, 4'd7);
        settle();
        chk("with_b", 32'(bus.b_flag), 1);
        chk("with_sreg", 32'(bus.sreg_idx), 3);
        chk("with_dreg", 32'(bus.dreg_idx), 3);
        chk("with_nostrobe", 32'(bus.move_strobe), 0);
        advance();
        set_op(1'b0, 2'b00, 4'd0);
        settle();
        chk("move_strobe", 32'(bus.move_strobe), 1);
        chk("move_b", 32'(bus.b_flag), 0);
        chk("move_sreg", 32'(bus.sreg_idx), 0);
        chk("move_dreg", 32'(bus.dreg_idx), 0);
        advance();
        settle();
        chk("move_pulse_end", 32'(bus.move_strobe), 0);

        // Hold register path.
        advance();
        bus.y         = 16'hBEEF;
        bus.hold_load = 1'b1;
        advance();
        bus.y         = 16'h0000;
        bus.hold_load = 1'b0;
        bus.xsel      = 2'b11;
`ifdef XSEL_OUT_REG_EN
        advance();
`endif
        settle();
        chk("hold_xbus", 32'(bus.xbus), 32'hBEEF);

        // Reset between edges during a prefix.
        advance();
        bus.xsel = 2'b00;
        set_op(1'b1, 2'b01, 4'd12);
        advance();
        set_op(1'b0, 2'b00, 4'd0);
        chk("pre_rst_sreg", 32'(bus.sreg_idx), 12);
        reset = 1'b1;
        #1;
        chk("async_rst_sreg", 32'(bus.sreg_idx), 0);
        chk("async_rst_strobe", 32'(bus.move_strobe), 0);
        chk("async_rst_hold_xbus_sel", 32'(bus.b_flag), 0);
        #1;
        reset = 1'b0;
        advance();
        set_op(1'b1, 2'b10, 4'd4);
        advance();
        set_op(1'b1, 2'b00, 4'd0);
        settle();
        chk("post_rst_dreg", 32'(bus.dreg_idx), 4);
        chk("post_rst_sreg", 32'(bus.sreg_idx), 0);
        chk("post_rst_nostrobe", 32'(bus.move_strobe), 0);
        advance();
        set_op(1'b0, 2'b00, 4'd0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREGS; i++) bus.regs[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            bus.y         = WIDTH'($urandom);
            bus.hold_load = ($urandom_range(0, 3) == 0);
            bus.xsel      = 2'($urandom_range(0, 3));
            bus.fix_idx   = RSEL_W'($urandom);
            set_op($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), RSEL_W'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
            advance();
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/x_operand_select_ctrl.md
X_OPERAND_SELECT_CTRL -- requirements
Module: x_operand_select_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: X-bus and register data width.
REQ-002 SHALL have parameter RSEL_W, default 4: register index width; NREGS = 2**RSEL_W registers.
REQ-003 SHALL have port clk  input  1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port regs  input  NREGS*WIDTH: flattened register file, Rn at bits [n*WIDTH +: WIDTH].
REQ-006 SHALL have port y  input  WIDTH: result bus.
REQ-007 SHALL have port hold_load  input  1: load y into the hold register.
REQ-008 SHALL have port op_valid  input  1: an instruction decode completes this cycle.
REQ-009 SHALL have port op_kind  input  2: 00 normal, 01 FROM, 10 TO, 11 WITH.
REQ-010 SHALL have port op_reg  input  RSEL_W: register operand of FROM/TO/WITH.
REQ-011 SHALL have port xsel  input  2: 00 Sreg, 01 fixed index, 10 y, 11 hold.
REQ-012 SHALL have port fix_idx  input  RSEL_W: register index used when xsel=01.
REQ-013 SHALL have port xbus  output  WIDTH: selected X operand.
REQ-014 SHALL have ports sreg_idx and dreg_idx  output  RSEL_W each: current source and destination indices.
REQ-015 SHALL have port b_flag  output  1: WITH prefix active.
REQ-016 SHALL have port move_strobe  output  1: one-cycle pulse when FROM/TO is executed as MOVES/MOVE.

Function
REQ-017 Selection SHALL be: xsel=00 -> R[sreg_idx]; 01 -> R[fix_idx]; 10 -> y; 11 -> hold register.
REQ-018 Hold register SHALL load y on the rising edge when hold_load=1, otherwise retain its value.
REQ-019 Prefix state SHALL be one of CLEAR, SRC (FROM seen), DST (TO seen), BOTH (FROM and TO seen), WITH.
REQ-020 With op_valid=0, sreg_idx, dreg_idx, b_flag and state SHALL hold.
REQ-021 With b_flag=0 and op_kind=FROM, the block SHALL set sreg_idx=op_reg; state CLEAR->SRC, DST->BOTH, SRC/BOTH unchanged.
REQ-022 With b_flag=0 and op_kind=TO, the block SHALL set dreg_idx=op_reg; state CLEAR->DST, SRC->BOTH, DST/BOTH unchanged.
REQ-023 On op_kind=WITH from any state, the block SHALL set sreg_idx=dreg_idx=op_reg, b_flag=1 and state=WITH.
REQ-024 With b_flag=1 and op_kind=FROM or TO, the block SHALL pulse move_strobe for one cycle and return to CLEAR with sreg_idx=dreg_idx=0 and b_flag=0.
REQ-025 On op_kind=normal, the block SHALL go to CLEAR with sreg_idx=dreg_idx=0 and b_flag=0 on that edge; xbus in that cycle SHALL still use the pre-clear sreg_idx.
REQ-026 Simultaneous hold_load and op_valid SHALL both take effect on the same edge, independently.
REQ-027 move_strobe SHALL be 0 in every cycle other than those in REQ-024.

Reset
REQ-028 Asserting reset SHALL immediately force state=CLEAR, sreg_idx=0, dreg_idx=0, b_flag=0, move_strobe=0 and hold=0, regardless of clk.
REQ-029 Reset asserted mid-prefix sequence SHALL discard the pending prefix; the first op after release SHALL behave as from CLEAR.

Configuration
REQ-030 With macro XSEL_OUT_REG_EN defined, xbus SHALL be registered: one-cycle latency, reset value 0.
REQ-031 With XSEL_OUT_REG_EN undefined, xbus SHALL be combinational from the current inputs and state: zero latency.

Verification
REQ-032 Reset, then xsel=00, R0=16'h1234 -> xbus=16'h1234, sreg_idx=0, dreg_idx=0, b_flag=0.
REQ-033 FROM op_reg=5, then TO op_reg=9, then normal op with R5=16'hA5A5 -> xbus=16'hA5A5 while state=BOTH and dreg_idx=9; indices clear to 0 after the normal op.
REQ-034 WITH op_reg=3, then TO op_reg=7 -> move_strobe pulses exactly one cycle, b_flag 1->0, sreg_idx and dreg_idx return to 0 (not 7).
REQ-035 y=16'hBEEF with hold_load=1, then y=16'h0000, xsel=11 -> xbus=16'hBEEF (one cycle later with XSEL_OUT_REG_EN).
REQ-036 FROM op_reg=12, reset pulsed between clock edges, then normal op -> sreg_idx=0 immediately on reset, no move_strobe, state stays CLEAR.
